// File: rtl/hydra_ingress_framer.sv
`default_nettype none
// ============================================================================
// hydra_ingress_framer - store-and-forward ingress adapter for one hydra port.
// Macro HYDRA_INGRESS_STATS_EN adds pkt_cnt/drop_cnt.        Rev 1.0
// ============================================================================
module hydra_ingress_framer #(
  parameter int DEPTH      = 512,
  parameter int DESC_DEPTH = 4,
  parameter int MAX_LEN    = 511
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  input  logic [3:0]  s_dest,
  input  logic [2:0]  s_prio,
  input  logic        pause,
  output logic        wr_sop,
  output logic        wr_vld,
  output logic [15:0] wr_data,
  output logic        wr_eop
`ifdef HYDRA_INGRESS_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int           AW        = $clog2(DEPTH);
  localparam int           DAW       = $clog2(DESC_DEPTH);
  localparam logic [AW:0]  PTR_ONE   = (AW + 1)'(1);
  localparam logic [DAW:0] DPTR_ONE  = (DAW + 1)'(1);
  localparam logic [9:0]   MAX_LEN_W = 10'(MAX_LEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SOP  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_EOP  = 3'd4;

  logic [15:0]  mem      [DEPTH];
  logic [15:0]  desc_mem [DESC_DEPTH];
  logic [AW:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [DAW:0] dwr_ptr, drd_ptr;
  logic         rst_state, first, discard;
  logic [9:0]   len_acc, len_nxt;
  logic [3:0]   dest_q;
  logic [2:0]   prio_q;
  logic         data_full, desc_full, desc_empty;
  logic         drop_word, accept, mem_we, desc_push, drop_pkt;
  logic [15:0]  desc_word;

  assign data_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign desc_full  = (dwr_ptr[DAW] != drd_ptr[DAW]) && (dwr_ptr[DAW-1:0] == drd_ptr[DAW-1:0]);
  assign desc_empty = (dwr_ptr == drd_ptr);

  // Words past MAX_LEN are swallowed without storage, so fullness must not stall them.
  assign drop_word = discard || (!first && (len_acc >= MAX_LEN_W));
  assign s_ready   = !rst_state && (drop_word || (!data_full && !desc_full));
  assign accept    = s_valid && s_ready;
  assign mem_we    = accept && !drop_word;
  assign desc_push = mem_we && s_last;
  assign drop_pkt  = accept && drop_word && s_last;
  assign len_nxt   = first ? 10'd1 : (len_acc + 10'd1);
  assign desc_word = {len_nxt[8:0], (first ? s_prio : prio_q), (first ? s_dest : dest_q)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_state  <= 1'b1;
      first      <= 1'b1;
      discard    <= 1'b0;
      len_acc    <= '0;
      dest_q     <= '0;
      prio_q     <= '0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      dwr_ptr    <= '0;
    end else begin
      rst_state <= 1'b0;
      if (accept) begin
        if (first) begin
          dest_q <= s_dest;
          prio_q <= s_prio;
        end
        if (mem_we) begin
          wr_ptr  <= wr_ptr + PTR_ONE;
          len_acc <= len_nxt;
        end
        if (s_last) begin
          first   <= 1'b1;
          discard <= 1'b0;
          if (drop_word) wr_ptr <= commit_ptr;
          else           commit_ptr <= wr_ptr + PTR_ONE;
        end else begin
          first   <= 1'b0;
          discard <= drop_word;
        end
      end
      if (desc_push) dwr_ptr <= dwr_ptr + DPTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)    mem[wr_ptr[AW-1:0]]       <= s_data;
    if (desc_push) desc_mem[dwr_ptr[DAW-1:0]] <= desc_word;
  end

  logic [2:0]  state, state_nxt;
  logic [15:0] hdr_q;
  logic [8:0]  cnt;
  logic        last_beat;
  logic        sop_d, vld_d, eop_d;
  logic [15:0] data_d;

  assign last_beat = (cnt == (hdr_q[15:7] - 9'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!desc_empty && !pause) state_nxt = S_SOP;
      S_SOP:   state_nxt = S_HDR;
      S_HDR:   state_nxt = S_DATA;
      S_DATA:  if (last_beat) state_nxt = S_EOP;
      S_EOP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q   <= '0;
      cnt     <= '0;
      rd_ptr  <= '0;
      drd_ptr <= '0;
    end else begin
      if (state == S_SOP) begin
        hdr_q   <= desc_mem[drd_ptr[DAW-1:0]];
        drd_ptr <= drd_ptr + DPTR_ONE;
        cnt     <= '0;
      end
      if (state == S_DATA) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        cnt    <= cnt + 9'd1;
      end
    end
  end

  // Outputs are decoded from the current state and registered, one cycle behind it.
  always_comb begin
    sop_d  = (state == S_SOP);
    vld_d  = (state == S_HDR) || (state == S_DATA);
    eop_d  = (state == S_EOP);
    data_d = '0;
    if (state == S_HDR)  data_d = hdr_q;
    if (state == S_DATA) data_d = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sop  <= 1'b0;
      wr_vld  <= 1'b0;
      wr_eop  <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_sop  <= sop_d;
      wr_vld  <= vld_d;
      wr_eop  <= eop_d;
      wr_data <= data_d;
    end
  end

`ifdef HYDRA_INGRESS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == S_EOP) pkt_cnt  <= pkt_cnt + 16'd1;
      if (drop_pkt)       drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_pkt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hydra_ingress_framer.sv
`default_nettype none
// ============================================================================
// tb_hydra_ingress_framer - directed self-checking bench for hydra_ingress_framer.
// Stats checks compile in with HYDRA_INGRESS_STATS_EN.         Rev 1.0
// ============================================================================
module tb_hydra_ingress_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] s_data = '0;
  logic [3:0]  s_dest = '0;
  logic [2:0]  s_prio = '0;
  logic        s_ready, wr_sop, wr_vld, wr_eop;
  logic [15:0] wr_data;
`ifdef HYDRA_INGRESS_STATS_EN
  logic [15:0] pkt_cnt, drop_cnt;
`endif

  int total = 0;
  int bad = 0;
  int sop_seen = 0;
  bit oneshot = 1'b0;

  always #5 clk = ~clk;

  hydra_ingress_framer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_dest  (s_dest),
    .s_prio  (s_prio),
    .pause   (pause),
    .wr_sop  (wr_sop),
    .wr_vld  (wr_vld),
    .wr_data (wr_data),
    .wr_eop  (wr_eop)
`ifdef HYDRA_INGRESS_STATS_EN
    ,
    .pkt_cnt (pkt_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; a word presented with oneshot set is withdrawn once accepted.
  task automatic tick();
    logic acc;
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (acc && oneshot) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      oneshot = 1'b0;
    end
    if (wr_sop) sop_seen++;
  endtask

  task automatic send_pkt(input int len, input logic [3:0] dst, input logic [2:0] pr,
                          input logic [15:0] base);
    int t;
    for (int i = 0; i < len; i++) begin
      s_valid = 1'b1;
      s_data  = base + 16'(i);
      s_last  = (i == len - 1);
      s_dest  = dst;
      s_prio  = pr;
      t = 0;
      while (!s_ready && t < 1000) begin
        tick();
        t++;
      end
      if (t >= 1000) chk("send_ready_timeout", 32'(s_ready), 32'd1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic recv_pkt(input int len, input logic [15:0] hdr, input logic [15:0] base,
                          input int pause_at);
    int t;
    t = 0;
    while (!wr_sop && t < 100) begin
      tick();
      t++;
    end
    chk("sop_latency", 32'(t), 32'd2);
    tick();
    chk("header", 32'({wr_vld, wr_data}), 32'({1'b1, hdr}));
    for (int i = 0; i < len; i++) begin
      tick();
      if (i == pause_at) pause = 1'b1;
      chk("data_word", 32'({wr_sop, wr_vld, wr_data}), 32'({2'b01, base + 16'(i)}));
    end
    tick();
    chk("eop", 32'({wr_sop, wr_vld, wr_eop}), 32'd1);
  endtask

  initial begin
    int t;
    int residual;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({wr_sop, wr_vld, wr_eop, s_ready, wr_data}), 32'd0);
`ifdef HYDRA_INGRESS_STATS_EN
    chk("reset_counters", {pkt_cnt, drop_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    tick();
    chk("ready_after_reset", 32'(s_ready), 32'd1);

    // 31 words, dest 3, prio 4
    send_pkt(31, 4'd3, 3'd4, 16'h1000);
    recv_pkt(31, 16'h0FC3, 16'h1000, -1);
`ifdef HYDRA_INGRESS_STATS_EN
    chk("pkt_cnt_one", 32'(pkt_cnt), 32'd1);
`endif

    // 34 words held back by pause for 20 cycles
    pause = 1'b1;
    sop_seen = 0;
    send_pkt(34, 4'd3, 3'd4, 16'h2000);
    repeat (20) tick();
    chk("no_sop_while_paused", 32'(sop_seen), 32'd0);
    pause = 1'b0;
    recv_pkt(34, 16'h1143, 16'h2000, -1);

    // pause raised mid-DATA must not interrupt the packet
    send_pkt(10, 4'd5, 3'd2, 16'h3000);
    recv_pkt(10, 16'h0525, 16'h3000, 4);
    pause = 1'b0;

    // 600-word packet is dropped, following packet intact
    sop_seen = 0;
    send_pkt(600, 4'd9, 3'd1, 16'h4000);
    repeat (5) tick();
    chk("overlen_no_sop", 32'(sop_seen), 32'd0);
`ifdef HYDRA_INGRESS_STATS_EN
    chk("drop_cnt_one", 32'(drop_cnt), 32'd1);
`endif
    send_pkt(5, 4'd1, 3'd7, 16'h5000);
    recv_pkt(5, 16'h02F1, 16'h5000, -1);

    // Fill to DEPTH: MAX_LEN packet plus one word, then the FIFO is full
    pause = 1'b1;
    send_pkt(511, 4'd15, 3'd7, 16'h6000);
    send_pkt(1, 4'd0, 3'd0, 16'hABCD);
    chk("full_at_depth", 32'(s_ready), 32'd0);
    pause = 1'b0;
    recv_pkt(511, 16'hFFFF, 16'h6000, -1);
    recv_pkt(1, 16'h0080, 16'hABCD, -1);

    // Descriptor FIFO fills after four single-word packets
    pause = 1'b1;
    for (int k = 0; k < 4; k++) send_pkt(1, 4'(k + 2), 3'd1, 16'h7000 + 16'(k));
    chk("desc_full_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    s_data  = 16'h7004;
    s_last  = 1'b1;
    s_dest  = 4'd6;
    s_prio  = 3'd1;
    oneshot = 1'b1;
    pause   = 1'b0;
    for (int k = 0; k < 5; k++) recv_pkt(1, 16'h0092 + 16'(k), 16'h7000 + 16'(k), -1);
    chk("fifth_accepted", 32'({s_valid, oneshot}), 32'd0);

    // Reset mid-DATA with a second packet still queued
    pause = 1'b1;
    send_pkt(10, 4'd2, 3'd3, 16'h8000);
    send_pkt(3, 4'd4, 3'd5, 16'h9000);
    pause = 1'b0;
    t = 0;
    while (!wr_sop && t < 20) begin
      tick();
      t++;
    end
    chk("rst_case_sop", 32'(t), 32'd2);
    tick();
    tick();
    tick();
    chk("rst_case_in_data", 32'({wr_vld, wr_data}), 32'({1'b1, 16'h8001}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({wr_sop, wr_vld, wr_eop, s_ready, wr_data}), 32'd0);
    #10 rst_n = 1'b1;
    sop_seen = 0;
    residual = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wr_vld || wr_eop) residual++;
    end
    chk("no_residual_packet", 32'(sop_seen + residual), 32'd0);
    chk("ready_after_midreset", 32'(s_ready), 32'd1);

    send_pkt(2, 4'd1, 3'd0, 16'hC000);
    recv_pkt(2, 16'h0101, 16'hC000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
